// File: rtl/decompressed_line_assembler.sv
// decompressed_line_assembler: packs pair/raw beats into lines with one fill buffer and one output register
module decompressed_line_assembler #(
    parameter int WIDTH      = 32,
    parameter int LINE_WORDS = 16,
    parameter int WIDTH_RAW  = 128
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic                          i_comp_flag,
    input  logic [WIDTH-1:0]              i_first_word,
    input  logic [WIDTH-1:0]              i_second_word,
    input  logic [WIDTH_RAW-1:0]          i_data,
    input  logic                          i_flush,
    output logic                          o_ready,
    output logic                          o_line_valid,
    output logic [LINE_WORDS*WIDTH-1:0]   o_line_data,
    input  logic                          i_line_ready,
    output logic [$clog2(LINE_WORDS):0]   o_word_count,
    output logic                          o_error,
    output logic [15:0]                   o_line_count
);
    localparam int CW        = $clog2(LINE_WORDS) + 1;
    localparam int RAW_WORDS = WIDTH_RAW / WIDTH;

    typedef enum logic {FILL, FULL} state_t;

    state_t                        state_q;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [LINE_WORDS*WIDTH-1:0]   fill_q, words_d, out_q;
    logic                          out_valid_q, err_q;
    logic [15:0]                   line_count_q;
    logic                          out_free, accept, aligned, flush_eff, complete;

    assign o_ready      = (state_q == FILL);
    assign o_line_valid = out_valid_q;
    assign o_line_data  = out_q;
    assign o_word_count = cnt_q;
    assign o_error      = err_q;
    assign o_line_count = line_count_q;
    assign out_free     = !out_valid_q || i_line_ready;
    assign accept       = i_valid && o_ready;
    assign aligned      = (int'(cnt_q) % RAW_WORDS) == 0;
    assign flush_eff    = i_flush && o_ready && (cnt_d != '0);
    assign complete     = o_ready && ((cnt_d == CW'(LINE_WORDS)) || flush_eff);

    // Fill buffer contents and count after this cycle's beat, with flush zero-padding applied
    always_comb begin
        words_d = fill_q;
        cnt_d   = cnt_q;
        if (accept && i_comp_flag) begin
            words_d[int'(cnt_q)*WIDTH +: WIDTH]       = i_first_word;
            words_d[(int'(cnt_q) + 1)*WIDTH +: WIDTH] = i_second_word;
            cnt_d = cnt_q + CW'(2);
        end else if (accept && aligned) begin
            for (int k = 0; k < RAW_WORDS; k++)
                words_d[(int'(cnt_q) + k)*WIDTH +: WIDTH] = i_data[k*WIDTH +: WIDTH];
            cnt_d = cnt_q + CW'(RAW_WORDS);
        end
        for (int k = 0; k < LINE_WORDS; k++)
            if (i_flush && o_ready && cnt_d != '0 && k >= int'(cnt_d))
                words_d[k*WIDTH +: WIDTH] = '0;
    end

    // FILL/FULL state machine with line handoff into the output register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            fill_q       <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            line_count_q <= '0;
        end else begin
            err_q <= accept && !i_comp_flag && !aligned;
            if (out_valid_q && i_line_ready)
                line_count_q <= line_count_q + 16'd1;
            if (state_q == FULL) begin
                if (out_free) begin
                    out_q       <= fill_q;
                    out_valid_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= FILL;
                end
            end else if (complete) begin
                if (out_free) begin
                    out_q       <= words_d;
                    out_valid_q <= 1'b1;
                    cnt_q       <= '0;
                end else begin
                    fill_q  <= words_d;
                    cnt_q   <= CW'(LINE_WORDS);
                    state_q <= FULL;
                end
            end else begin
                fill_q      <= words_d;
                cnt_q       <= cnt_d;
                out_valid_q <= out_valid_q && !i_line_ready;
            end
        end
    end
endmodule

// File: tb/tb_decompressed_line_assembler.sv
// tb_decompressed_line_assembler: randomized scoreboard bench against a word-list line model
module tb_decompressed_line_assembler;
    localparam int W = 32;
    localparam int L = 16;
    localparam int R = 128;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0, comp = 1'b0, flush = 1'b0, lready = 1'b0;
    logic [W-1:0]     w0 = '0, w1 = '0;
    logic [R-1:0]     data = '0;
    logic             ready, lvalid, err;
    logic [L*W-1:0]   ldata;
    logic [4:0]       wc;
    logic [15:0]      lc;

    decompressed_line_assembler #(.WIDTH(W), .LINE_WORDS(L), .WIDTH_RAW(R)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_comp_flag(comp),
        .i_first_word(w0), .i_second_word(w1), .i_data(data), .i_flush(flush),
        .o_ready(ready), .o_line_valid(lvalid), .o_line_data(ldata),
        .i_line_ready(lready), .o_word_count(wc), .o_error(err), .o_line_count(lc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [L*W-1:0] exp_q[$];
    logic [W-1:0]   fill[$];
    int             handed = 0;
    bit             err_exp = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops the oldest expected line
    always @(negedge clk) begin
        if (!rst && lvalid && lready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL line: unexpected line %h", ldata);
            end else begin
                if (ldata !== exp_q[0]) begin
                    errors++;
                    $display("FAIL line: got %h expected %h", ldata, exp_q[0]);
                end
                void'(exp_q.pop_front());
                handed++;
            end
        end
    end

    task automatic step(bit v, bit c, logic [W-1:0] a, logic [W-1:0] b, logic [R-1:0] d, bit f, bit r);
        logic [L*W-1:0] ln;
        chk("ready", ready, exp_q.size() < 2);
        chk("line_valid", lvalid, exp_q.size() > 0);
        chk("word_count", wc, exp_q.size() == 2 ? 16 : fill.size());
        chk("error", err, err_exp);
        chk("line_count", lc, handed & 16'hffff);
        err_exp = 0;
        valid = v; comp = c; w0 = a; w1 = b; data = d; flush = f; lready = r;
        if (exp_q.size() < 2) begin
            if (v && c) begin
                fill.push_back(a);
                fill.push_back(b);
            end else if (v && fill.size() % 4 == 0) begin
                for (int k = 0; k < 4; k++) fill.push_back(d[k*W +: W]);
            end else if (v) begin
                err_exp = 1;
            end
            if (fill.size() == L || (f && fill.size() > 0)) begin
                ln = '0;
                foreach (fill[k]) ln[k*W +: W] = fill[k];
                exp_q.push_back(ln);
                fill.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n, bit r);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, r);
    endtask

    task automatic pairs(int n, int base, bit r);
        for (int i = 0; i < n; i++) step(1, 1, W'(base + 2*i), W'(base + 2*i + 1), '0, 0, r);
    endtask

    task automatic do_reset();
        rst = 1; valid = 0; flush = 0; lready = 0;
        fill.delete();
        exp_q.delete();
        handed = 0;
        err_exp = 0;
        @(posedge clk);
        #1;
        rst = 0;
        chk("reset_data_zero", ldata == '0, 1);
    endtask

    logic [R-1:0] raw_pat;

    initial begin
        raw_pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        @(posedge clk);
        #1;
        do_reset();
        // pair stream
        pairs(8, 'h100, 1);
        idle(3, 1);
        // backpressure: two lines held, then released
        pairs(16, 'h200, 0);
        idle(2, 0);
        idle(4, 1);
        // raw stream
        for (int i = 0; i < 4; i++) step(1, 0, '0, '0, raw_pat, 0, 1);
        idle(2, 1);
        // misaligned raw beat
        pairs(1, 'h300, 1);
        step(1, 0, '0, '0, raw_pat, 0, 1);
        pairs(7, 'h302, 1);
        idle(2, 1);
        // flush partial line, then flush at empty
        pairs(3, 'h400, 1);
        step(0, 0, '0, '0, '0, 1, 1);
        idle(2, 1);
        step(0, 0, '0, '0, '0, 1, 1);
        idle(2, 1);
        // reset mid-fill with a held line
        pairs(8, 'h500, 0);
        pairs(5, 'h510, 0);
        idle(1, 0);
        do_reset();
        pairs(8, 'h600, 1);
        idle(3, 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1, 1);
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
